// File: rtl/ysyx_23060025_bus_arbiter_n_pkg.sv
// Shared state codes, priority-mode constants and sizing helper for the N-master bus arbiter.
package ysyx_23060025_bus_arbiter_n_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic ARB_PRIO_RR    = 1'b0;
  localparam logic ARB_PRIO_FIXED = 1'b1;

  // A one-master arbiter still needs a 1-bit index so the registers stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060025_bus_arbiter_n_rr_picker.sv
// Combinational winner selection: round-robin from ptr, or lowest index in fixed mode.
// Zero latency; no state, no backpressure.
module ysyx_23060025_rr_picker
  import ysyx_23060025_bus_arbiter_n_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  int start_pos;
  assign start_pos = (mode == ARB_PRIO_FIXED) ? 0 : int'(ptr);

  // First pass covers [start_pos, N-1]; the second wraps round to index 0.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (j >= start_pos)) begin
        any      = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && req[j]) begin
        any      = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ysyx_23060025_bus_arbiter_n.sv
// N-master to 1-slave memory bus arbiter: request in cycle k drives s_psel in k+1, slave
// responses forwarded combinationally to the owner; other masters wait until the owner completes.
module ysyx_23060025_bus_arbiter_n
  import ysyx_23060025_bus_arbiter_n_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_LEN    = 32,
  parameter int DATA_LEN    = 32,
  parameter int LEN_W       = 8,
  parameter int PRIO_MODE   = 0
) (
  input  logic                                  clock,
  input  logic                                  rstn,
  input  logic [NUM_MASTERS*ADDR_LEN-1:0]       m_paddr,
  input  logic [NUM_MASTERS-1:0]                m_psel,
  input  logic [NUM_MASTERS-1:0]                m_pwrite,
  input  logic [NUM_MASTERS*3-1:0]              m_psize,
  input  logic [NUM_MASTERS*LEN_W-1:0]          m_plen,
  input  logic [NUM_MASTERS*DATA_LEN-1:0]       m_pwdata,
  input  logic [NUM_MASTERS*(DATA_LEN/8)-1:0]   m_pwstrb,
  output logic [DATA_LEN-1:0]                   m_prdata,
  output logic [NUM_MASTERS-1:0]                m_pvalid,
  output logic [NUM_MASTERS-1:0]                m_plast,
  output logic [ADDR_LEN-1:0]                   s_paddr,
  output logic                                  s_psel,
  output logic                                  s_pwrite,
  output logic [2:0]                            s_psize,
  output logic [LEN_W-1:0]                      s_plen,
  output logic [DATA_LEN-1:0]                   s_pwdata,
  output logic [DATA_LEN/8-1:0]                 s_pwstrb,
  input  logic [DATA_LEN-1:0]                   s_prdata,
  input  logic                                  s_pvalid,
  input  logic                                  s_plast,
  output logic [NUM_MASTERS-1:0]                grant_o,
  output logic                                  proto_err
);

  localparam int   N      = NUM_MASTERS;
  localparam int   STRB_W = DATA_LEN / 8;
  localparam int   IDX_W  = idx_width(N);
  localparam logic MODE   = (PRIO_MODE != 0) ? ARB_PRIO_FIXED : ARB_PRIO_RR;

  arb_state_e        state, state_nxt;
  logic [N-1:0]      grant_q, grant_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [LEN_W:0]    cnt, cnt_nxt;
  logic [N-1:0]      pick;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              busy;
  logic              done;

  ysyx_23060025_rr_picker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_picker (
    .req      (m_psel),
    .ptr      (ptr),
    .mode     (MODE),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    if (state == ARB_IDLE) begin
      if (pick_any) begin
        state_nxt = ARB_BUSY;
        grant_nxt = pick;
        cnt_nxt   = '0;
        if (MODE == ARB_PRIO_RR) begin
          ptr_nxt = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
    end else begin
      if (s_pvalid) begin
        cnt_nxt = cnt + 1'b1;
      end
      if (done) begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    end
  end

  // grant_q is one-hot while busy and zero otherwise, so it doubles as the mux select.
  always_comb begin
    s_paddr  = '0;
    s_pwrite = 1'b0;
    s_psize  = '0;
    s_plen   = '0;
    s_pwdata = '0;
    s_pwstrb = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        s_paddr  = m_paddr[i*ADDR_LEN +: ADDR_LEN];
        s_pwrite = m_pwrite[i];
        s_psize  = m_psize[i*3 +: 3];
        s_plen   = m_plen[i*LEN_W +: LEN_W];
        s_pwdata = m_pwdata[i*DATA_LEN +: DATA_LEN];
        s_pwstrb = m_pwstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign busy     = (state == ARB_BUSY);
  assign s_psel   = busy;
  assign grant_o  = grant_q;
  assign m_prdata = s_prdata;
  assign m_pvalid = grant_q & {N{s_pvalid}};
  assign m_plast  = grant_q & {N{s_plast}};
  assign done     = busy & s_pvalid & (s_pwrite | s_plast);

  // A read must end exactly when the beat count equals plen; only s_plast actually ends it.
  assign proto_err = busy & ~s_pwrite & s_pvalid &
                     (s_plast ? (cnt != {1'b0, s_plen}) : (cnt == {1'b0, s_plen}));

endmodule

// File: tb/tb_ysyx_23060025_bus_arbiter_n.sv
// Directed bench: a 2-master RR, a 3-master fixed-priority and a 4-master RR instance share one slave model.
module tb_ysyx_23060025_bus_arbiter_n;

  logic        clock;
  logic        rstn;
  logic [31:0] s_prdata;
  logic        s_pvalid;
  logic        s_plast;

  int checks = 0;
  int errors = 0;

  // Instance A: N=2, round-robin
  logic [63:0] a_paddr;
  logic [1:0]  a_psel, a_pwrite;
  logic [5:0]  a_psize;
  logic [15:0] a_plen;
  logic [63:0] a_pwdata;
  logic [7:0]  a_pwstrb;
  logic [31:0] a_prdata;
  logic [1:0]  a_pvalid, a_plast, a_grant;
  logic [31:0] a_s_paddr, a_s_pwdata;
  logic        a_s_psel, a_s_pwrite, a_perr;
  logic [2:0]  a_s_psize;
  logic [7:0]  a_s_plen;
  logic [3:0]  a_s_pwstrb;

  // Instance B: N=3, fixed priority
  logic [95:0] b_paddr;
  logic [2:0]  b_psel, b_pwrite;
  logic [8:0]  b_psize;
  logic [23:0] b_plen;
  logic [95:0] b_pwdata;
  logic [11:0] b_pwstrb;
  logic [31:0] b_prdata;
  logic [2:0]  b_pvalid, b_plast, b_grant;
  logic [31:0] b_s_paddr, b_s_pwdata;
  logic        b_s_psel, b_s_pwrite, b_perr;
  logic [2:0]  b_s_psize;
  logic [7:0]  b_s_plen;
  logic [3:0]  b_s_pwstrb;

  // Instance C: N=4, round-robin
  logic [127:0] c_paddr;
  logic [3:0]   c_psel, c_pwrite;
  logic [11:0]  c_psize;
  logic [31:0]  c_plen;
  logic [127:0] c_pwdata;
  logic [15:0]  c_pwstrb;
  logic [31:0]  c_prdata;
  logic [3:0]   c_pvalid, c_plast, c_grant;
  logic [31:0]  c_s_paddr, c_s_pwdata;
  logic         c_s_psel, c_s_pwrite, c_perr;
  logic [2:0]   c_s_psize;
  logic [7:0]   c_s_plen;
  logic [3:0]   c_s_pwstrb;

  ysyx_23060025_bus_arbiter_n #(.NUM_MASTERS(2), .PRIO_MODE(0)) dut_a (
    .clock(clock), .rstn(rstn),
    .m_paddr(a_paddr), .m_psel(a_psel), .m_pwrite(a_pwrite), .m_psize(a_psize),
    .m_plen(a_plen), .m_pwdata(a_pwdata), .m_pwstrb(a_pwstrb),
    .m_prdata(a_prdata), .m_pvalid(a_pvalid), .m_plast(a_plast),
    .s_paddr(a_s_paddr), .s_psel(a_s_psel), .s_pwrite(a_s_pwrite), .s_psize(a_s_psize),
    .s_plen(a_s_plen), .s_pwdata(a_s_pwdata), .s_pwstrb(a_s_pwstrb),
    .s_prdata(s_prdata), .s_pvalid(s_pvalid), .s_plast(s_plast),
    .grant_o(a_grant), .proto_err(a_perr)
  );

  ysyx_23060025_bus_arbiter_n #(.NUM_MASTERS(3), .PRIO_MODE(1)) dut_b (
    .clock(clock), .rstn(rstn),
    .m_paddr(b_paddr), .m_psel(b_psel), .m_pwrite(b_pwrite), .m_psize(b_psize),
    .m_plen(b_plen), .m_pwdata(b_pwdata), .m_pwstrb(b_pwstrb),
    .m_prdata(b_prdata), .m_pvalid(b_pvalid), .m_plast(b_plast),
    .s_paddr(b_s_paddr), .s_psel(b_s_psel), .s_pwrite(b_s_pwrite), .s_psize(b_s_psize),
    .s_plen(b_s_plen), .s_pwdata(b_s_pwdata), .s_pwstrb(b_s_pwstrb),
    .s_prdata(s_prdata), .s_pvalid(s_pvalid), .s_plast(s_plast),
    .grant_o(b_grant), .proto_err(b_perr)
  );

  ysyx_23060025_bus_arbiter_n #(.NUM_MASTERS(4), .PRIO_MODE(0)) dut_c (
    .clock(clock), .rstn(rstn),
    .m_paddr(c_paddr), .m_psel(c_psel), .m_pwrite(c_pwrite), .m_psize(c_psize),
    .m_plen(c_plen), .m_pwdata(c_pwdata), .m_pwstrb(c_pwstrb),
    .m_prdata(c_prdata), .m_pvalid(c_pvalid), .m_plast(c_plast),
    .s_paddr(c_s_paddr), .s_psel(c_s_psel), .s_pwrite(c_s_pwrite), .s_psize(c_s_psize),
    .s_plen(c_s_plen), .s_pwdata(c_s_pwdata), .s_pwstrb(c_s_pwstrb),
    .s_prdata(s_prdata), .s_pvalid(s_pvalid), .s_plast(s_plast),
    .grant_o(c_grant), .proto_err(c_perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    s_prdata = '0; s_pvalid = 1'b0; s_plast = 1'b0;
    a_paddr = '0; a_psel = '0; a_pwrite = '0; a_psize = '0; a_plen = '0; a_pwdata = '0; a_pwstrb = '0;
    b_paddr = '0; b_psel = '0; b_pwrite = '0; b_psize = '0; b_plen = '0; b_pwdata = '0; b_pwstrb = '0;
    c_paddr = '0; c_psel = '0; c_pwrite = '0; c_psize = '0; c_plen = '0; c_pwdata = '0; c_pwstrb = '0;
    tick;
    tick;
    rstn = 1'b1;
    #1;
    checks++; if (a_s_psel !== 1'b0) begin errors++; $display("FAIL reset_s_psel: got %b want 0", a_s_psel); end
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant_a: got %b want 00", a_grant); end
    checks++; if (a_pvalid !== 2'b00) begin errors++; $display("FAIL reset_pvalid: got %b want 00", a_pvalid); end
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", a_perr); end
    checks++; if (a_s_paddr !== 32'h0) begin errors++; $display("FAIL reset_s_paddr: got %h want 0", a_s_paddr); end
    checks++; if (b_grant !== 3'b000) begin errors++; $display("FAIL reset_grant_b: got %b want 000", b_grant); end
    checks++; if (c_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant_c: got %b want 0000", c_grant); end
  endtask

  task automatic test_single_read;
    a_paddr[31:0] = 32'h8000_0000;
    a_plen[7:0]   = 8'd3;
    a_pwrite      = 2'b00;
    a_psel        = 2'b01;
    #1;
    checks++; if (a_s_psel !== 1'b0) begin errors++; $display("FAIL read_latency: s_psel got %b want 0 before edge", a_s_psel); end
    tick;
    checks++; if (a_s_psel !== 1'b1) begin errors++; $display("FAIL read_s_psel: got %b want 1", a_s_psel); end
    checks++; if (a_s_paddr !== 32'h8000_0000) begin errors++; $display("FAIL read_s_paddr: got %h want 80000000", a_s_paddr); end
    checks++; if (a_s_plen !== 8'd3) begin errors++; $display("FAIL read_s_plen: got %0d want 3", a_s_plen); end
    checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL read_grant: got %b want 01", a_grant); end
    for (int i = 0; i < 4; i++) begin
      s_pvalid = 1'b1;
      s_plast  = (i == 3);
      s_prdata = 32'hD000_0000 + 32'(i);
      #1;
      checks++; if (a_pvalid !== 2'b01) begin errors++; $display("FAIL read_pvalid beat%0d: got %b want 01", i, a_pvalid); end
      checks++; if (a_plast !== ((i == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL read_plast beat%0d: got %b", i, a_plast); end
      checks++; if (a_prdata !== 32'hD000_0000 + 32'(i)) begin errors++; $display("FAIL read_prdata beat%0d: got %h", i, a_prdata); end
      checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL read_no_err beat%0d: got %b want 0", i, a_perr); end
      tick;
    end
    a_psel = 2'b00; s_pvalid = 1'b0; s_plast = 1'b0;
    #1;
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL read_idle_grant: got %b want 00", a_grant); end
    checks++; if (a_s_psel !== 1'b0) begin errors++; $display("FAIL read_idle_s_psel: got %b want 0", a_s_psel); end
  endtask

  task automatic test_contention_rr;
    logic [1:0]  exp;
    logic [31:0] exp_wd;
    rstn = 1'b0;
    tick;
    rstn = 1'b1;
    a_pwrite = 2'b11;
    a_pwdata = {32'hB1B1_0001, 32'hA0A0_0000};
    a_pwstrb = 8'hFF;
    a_psel   = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp    = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_wd = (t % 2 == 0) ? 32'hA0A0_0000 : 32'hB1B1_0001;
      tick;
      checks++; if (a_grant !== exp) begin errors++; $display("FAIL rr_grant t%0d: got %b want %b", t, a_grant, exp); end
      checks++; if (a_s_pwdata !== exp_wd) begin errors++; $display("FAIL rr_pwdata t%0d: got %h want %h", t, a_s_pwdata, exp_wd); end
      s_pvalid = 1'b1;
      #1;
      checks++; if (a_pvalid !== exp) begin errors++; $display("FAIL rr_pvalid t%0d: got %b want %b", t, a_pvalid, exp); end
      tick;
      s_pvalid = 1'b0;
      if (t == 3) a_psel = 2'b00;
      #1;
      checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL rr_idle_gap t%0d: got %b want 00", t, a_grant); end
    end
  endtask

  task automatic test_proto_err;
    a_pwrite    = 2'b00;
    a_plen[7:0] = 8'd1;
    a_psel      = 2'b01;
    tick;
    // plen=1 expects two beats: the 2nd beat lacks plast, the 3rd carries plast at the wrong count.
    for (int i = 0; i < 3; i++) begin
      s_pvalid = 1'b1;
      s_plast  = (i == 2);
      #1;
      checks++; if (a_perr !== (i >= 1)) begin errors++; $display("FAIL perr beat%0d: got %b want %b", i, a_perr, (i >= 1)); end
      checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL perr_owner beat%0d: got %b want 01", i, a_grant); end
      tick;
    end
    a_psel = 2'b00; s_pvalid = 1'b0; s_plast = 1'b0;
    #1;
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL perr_end: got %b want 00", a_grant); end
  endtask

  task automatic test_reset_mid_burst;
    a_pwrite    = 2'b00;
    a_plen[7:0] = 8'd3;
    a_psel      = 2'b01;
    tick;
    s_pvalid = 1'b1;
    tick;
    rstn   = 1'b0;
    a_psel = 2'b00;
    tick;
    rstn = 1'b1;
    #1;
    checks++; if (a_s_psel !== 1'b0) begin errors++; $display("FAIL rst_mid_s_psel: got %b want 0", a_s_psel); end
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL rst_mid_grant: got %b want 00", a_grant); end
    checks++; if (a_pvalid !== 2'b00) begin errors++; $display("FAIL rst_mid_pvalid: got %b want 00", a_pvalid); end
    a_pwrite = 2'b11;
    a_psel   = 2'b11;
    tick;
    checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL rst_ptr_zero: got %b want 01", a_grant); end
    checks++; if (a_pvalid !== 2'b01) begin errors++; $display("FAIL rst_fresh_ack: got %b want 01", a_pvalid); end
    a_psel = 2'b00;
    tick;
    s_pvalid = 1'b0;
    #1;
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL rst_fresh_end: got %b want 00", a_grant); end
  endtask

  task automatic test_fixed_prio;
    b_pwrite = 3'b111;
    b_psel   = 3'b111;
    for (int t = 0; t < 3; t++) begin
      tick;
      checks++; if (b_grant !== 3'b001) begin errors++; $display("FAIL fixed_m0 t%0d: got %b want 001", t, b_grant); end
      s_pvalid = 1'b1;
      #1;
      checks++; if (b_pvalid !== 3'b001) begin errors++; $display("FAIL fixed_pvalid t%0d: got %b want 001", t, b_pvalid); end
      tick;
      s_pvalid = 1'b0;
      if (t == 2) b_psel = 3'b110;
      #1;
      checks++; if (b_grant !== 3'b000) begin errors++; $display("FAIL fixed_idle t%0d: got %b want 000", t, b_grant); end
    end
    tick;
    checks++; if (b_grant !== 3'b010) begin errors++; $display("FAIL fixed_m1: got %b want 010", b_grant); end
    s_pvalid = 1'b1;
    b_psel   = 3'b100;
    tick;
    s_pvalid = 1'b0;
    tick;
    checks++; if (b_grant !== 3'b100) begin errors++; $display("FAIL fixed_m2: got %b want 100", b_grant); end
    s_pvalid = 1'b1;
    b_psel   = 3'b000;
    #1;
    checks++; if (b_pvalid !== 3'b100) begin errors++; $display("FAIL fixed_m2_pvalid: got %b want 100", b_pvalid); end
    tick;
    s_pvalid = 1'b0;
    #1;
    checks++; if (b_grant !== 3'b000) begin errors++; $display("FAIL fixed_end: got %b want 000", b_grant); end
  endtask

  task automatic test_rr_wrap;
    logic [3:0] wexp [3];
    wexp = '{4'b1000, 4'b0001, 4'b0010};
    c_pwrite = 4'hF;
    c_psel   = 4'b0100;
    tick;
    checks++; if (c_grant !== 4'b0100) begin errors++; $display("FAIL wrap_m2: got %b want 0100", c_grant); end
    s_pvalid = 1'b1;
    c_psel   = 4'b1111;
    tick;
    s_pvalid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick;
      checks++; if (c_grant !== wexp[t]) begin errors++; $display("FAIL wrap_grant t%0d: got %b want %b", t, c_grant, wexp[t]); end
      s_pvalid = 1'b1;
      #1;
      checks++; if (c_pvalid !== wexp[t]) begin errors++; $display("FAIL wrap_pvalid t%0d: got %b want %b", t, c_pvalid, wexp[t]); end
      tick;
      s_pvalid = 1'b0;
      if (t == 2) c_psel = 4'b0000;
      #1;
      checks++; if (c_grant !== 4'b0000) begin errors++; $display("FAIL wrap_idle t%0d: got %b want 0000", t, c_grant); end
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_contention_rr;
    test_proto_err;
    test_reset_mid_burst;
    test_fixed_prio;
    test_rr_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
